pb_input_port: RTL and testbench

Debounced, interrupt-capable input peripheral for the KCPSM6 (PicoBlaze) read path. It synchronises and debounces the 8 slide switches and 5 push buttons and latches button press events. It also drives the processor's `in_port` from `port_id` on every cycle and clears the event register on a `read_strobe` of the event port. It sits beside the processor in the top level, complementing the write-strobe output register that drives the LEDs.

---
 rtl/pb_input_port.sv | 96 +++++++++
 tb/tb_pb_input_port.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pb_input_port.sv
// PicoBlaze input peripheral: synchronised, debounced switches and buttons
// with latched, clear-on-read button-press events and a registered read mux.
module pb_input_port #(
    parameter logic [7:0]  SW_PORT         = 8'h00,
    parameter logic [7:0]  BTN_PORT        = 8'h01,
    parameter logic [7:0]  EVT_PORT        = 8'h03,
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned CNT_W           = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    input  logic [4:0] btn,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic       event_pending
);

    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bits 7:0 are switches, bits 12:8 are buttons.
    logic [12:0]      s1;
    logic [12:0]      s;
    logic [12:0]      db;
    logic [12:0]      db_next;
    logic [CNT_W-1:0] cnt [13];
    logic [4:0]       evt;
    logic [4:0]       rise;
    logic [4:0]       evt_next;
    logic             clr;
    logic [7:0]       rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s  <= '0;
        end else begin
            s1 <= {btn, sw};
            s  <= s1;
        end
    end

    always_comb begin
        db_next = db;
        for (int i = 0; i < 13; i++) begin
            if (s[i] != db[i] && cnt[i] == CNT_LAST)
                db_next[i] = s[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db <= '0;
            for (int i = 0; i < 13; i++)
                cnt[i] <= '0;
        end else begin
            db <= db_next;
            for (int i = 0; i < 13; i++) begin
                if (s[i] == db[i] || cnt[i] == CNT_LAST)
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    // A press landing on the clearing read survives the clear.
    assign rise     = db_next[12:8] & ~db[12:8];
    assign clr      = read_strobe && (port_id == EVT_PORT);
    assign evt_next = (clr ? 5'b0 : evt) | rise;

    always_comb begin
        rd_data = 8'h00;
        if (port_id == SW_PORT)
            rd_data = db[7:0];
        else if (port_id == BTN_PORT)
            rd_data = {3'b0, db[12:8]};
        else if (port_id == EVT_PORT)
            rd_data = {3'b0, evt};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt           <= '0;
            event_pending <= 1'b0;
            in_port       <= 8'h00;
        end else begin
            evt           <= evt_next;
            event_pending <= |evt_next;
            in_port       <= rd_data;
        end
    end

endmodule

// File: tb/tb_pb_input_port.sv
// Randomised and directed bench for pb_input_port with a reference model
// and a read scoreboard.
module tb_pb_input_port;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw = 8'h00;
    logic [4:0] btn = 5'h00;
    logic [7:0] port_id = 8'h00;
    logic       read_strobe = 1'b0;
    logic [7:0] in_port;
    logic       event_pending;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    logic [7:0] exp_q [$];

    pb_input_port #(
        .SW_PORT(8'h00),
        .BTN_PORT(8'h01),
        .EVT_PORT(8'h03),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw(sw),
        .btn(btn),
        .port_id(port_id),
        .read_strobe(read_strobe),
        .in_port(in_port),
        .event_pending(event_pending)
    );

    always #5 clk = ~clk;

    // Reference model: pins reach the filter two edges late; a level is
    // accepted once it has disagreed with the accepted level DB edges running.
    bit [12:0] m_p1, m_p2, m_acc;
    int        m_run [13];
    bit [4:0]  m_evt;

    always @(posedge clk) begin : model
        bit [12:0] nacc;
        bit [4:0]  pressed;
        if (rst) begin
            m_p1 = '0;
            m_p2 = '0;
            m_acc = '0;
            m_evt = '0;
            for (int i = 0; i < 13; i++) m_run[i] = 0;
        end else begin
            nacc = m_acc;
            for (int i = 0; i < 13; i++) begin
                if (m_p2[i] != m_acc[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DB) begin
                        nacc[i] = m_p2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            pressed = nacc[12:8] & ~m_acc[12:8];
            if (read_strobe && port_id == 8'h03) m_evt = pressed;
            else m_evt = m_evt | pressed;
            m_acc = nacc;
            m_p2 = m_p1;
            m_p1 = {btn, sw};
        end
    end

    function automatic logic [7:0] exp_mux(input logic [7:0] pid);
        case (pid)
            8'h00:   return m_acc[7:0];
            8'h01:   return {3'b0, m_acc[12:8]};
            8'h03:   return {3'b0, m_evt};
            default: return 8'h00;
        endcase
    endfunction

    task automatic check8(input string name, input logic [7:0] act,
                          input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: interrupt line every cycle, read data on each strobe.
    always @(negedge clk) begin
        if (started && !rst) begin
            checks++;
            if (event_pending !== (|m_evt)) begin
                errors++;
                $display("FAIL event_pending: got %b expected %b at %0t",
                         event_pending, |m_evt, $time);
            end
            if (read_strobe) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL read_unexpected: got %h expected none",
                             in_port);
                end else begin
                    check8("read_data", in_port, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        read_strobe = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] pid);
        port_id = pid;
        read_strobe = 1'b0;
        exp_q.push_back(exp_mux(pid));
        tick();
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pid;
        int r;

        // Reset
        do_reset(3);
        started = 1;
        check8("reset_in_port", in_port, 8'h00);
        check8("reset_pending", {7'b0, event_pending}, 8'h00);
        do_read(8'h00);

        // Switch debounce latency: value appears on the 7th edge
        port_id = 8'h00;
        tick();
        sw = 8'hA5;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            check8($sformatf("sw_latency_%0d", k), in_port,
                   (k >= 7) ? 8'hA5 : 8'h00);
        end
        tick();

        // Glitch reject
        btn = 5'b00001;
        repeat (3) tick();
        btn = 5'b00000;
        repeat (10) tick();
        do_read(8'h03);
        do_read(8'h01);

        // Press and clear
        btn = 5'b00100;
        repeat (8) tick();
        do_read(8'h03);
        do_read(8'h03);
        do_read(8'h01);
        btn = 5'b00000;
        repeat (8) tick();

        // Simultaneous set and clear
        btn = 5'b00001;
        repeat (8) tick();
        btn = 5'b00011;
        repeat (4) tick();
        do_read(8'h03);
        check8("simul_pending", {7'b0, event_pending}, 8'h01);
        do_read(8'h03);
        btn = 5'b00000;
        repeat (8) tick();

        // Reset mid-debounce, then unmapped port
        btn = 5'b01000;
        repeat (4) tick();
        do_reset(2);
        repeat (8) tick();
        do_read(8'h7F);
        do_read(8'h03);
        btn = 5'b00000;
        repeat (8) tick();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 8)
                sw[$urandom_range(0, 7)] ^= 1'b1;
            else if (r < 14)
                btn[$urandom_range(0, 4)] ^= 1'b1;
            if ($urandom_range(0, 399) == 0) begin
                do_reset(1);
            end else if (r >= 20 && r < 45) begin
                case ($urandom_range(0, 4))
                    0:       pid = 8'h00;
                    1:       pid = 8'h01;
                    2, 3:    pid = 8'h03;
                    default: pid = 8'($urandom_range(0, 255));
                endcase
                do_read(pid);
            end else begin
                tick();
            end
        end

        repeat (3) tick();
        check8("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
